// File: rtl/am2910_sequencer.sv
// Am2910-style microprogram sequencer: next-address mux, uPC, loop counter R
// and a small subroutine/loop stack.
module am2910_sequencer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       i,
  input  logic [WIDTH-1:0] d,
  input  logic             cond,
  input  logic             ccen,
  input  logic             rld,
  input  logic             ci,
  output logic [WIDTH-1:0] y,
  output logic             full,
  output logic             pl_en,
  output logic             map_en,
  output logic             vect_en
);

  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
    RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
  } op_e;

  logic [WIDTH-1:0] upc_q, upc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic             pass, rz;
  logic [WIDTH-1:0] f;
  logic             push, pop, clr, r_ld, r_dec;

  assign pass = !ccen | cond;
  assign rz   = (r_q == '0);

  // Stack top; an empty stack reads as zero regardless of stale contents.
  always_comb begin
    f = '0;
    for (int k = 0; k < DEPTH; k++)
      if (sp_q == SPW'(k + 1)) f = stack_q[k];
  end

  always_comb begin
    y     = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    r_ld  = 1'b0;
    r_dec = 1'b0;
    case (op_e'(i))
      JZ:   begin y = '0; clr = 1'b1; end
      CJS:  if (pass) begin y = d; push = 1'b1; end
      JMAP: y = d;
      CJP:  if (pass) y = d;
      PUSH: begin push = 1'b1; r_ld = pass; end
      JSRP: begin y = pass ? d : r_q; push = 1'b1; end
      CJV:  if (pass) y = d;
      JRP:  y = pass ? d : r_q;
      RFCT: if (!rz) begin y = f; r_dec = 1'b1; end
            else pop = 1'b1;
      RPCT: if (!rz) begin y = d; r_dec = 1'b1; end
      CRTN: if (pass) begin y = f; pop = 1'b1; end
      CJPP: if (pass) begin y = d; pop = 1'b1; end
      LDCT: r_ld = 1'b1;
      LOOP: if (pass) pop = 1'b1;
            else y = f;
      CONT: ;
      TWB: begin
        if (!rz && !pass) begin
          y = f; r_dec = 1'b1;
        end else begin
          pop = 1'b1;
          if (rz && !pass) y = d;
        end
      end
      default: ;
    endcase
  end

  assign map_en  = (i == 4'd2);
  assign vect_en = (i == 4'd6);
  assign pl_en   = !(map_en | vect_en);

  always_comb begin
    upc_d = y + {{(WIDTH-1){1'b0}}, ci};

    r_d = r_q;
    if (rld || r_ld) r_d = d;
    else if (r_dec)  r_d = r_q - WIDTH'(1);

    sp_d = sp_q;
    if (clr)
      sp_d = '0;
    else if (push && sp_q != SPW'(DEPTH))
      sp_d = sp_q + SPW'(1);
    else if (pop && sp_q != '0)
      sp_d = sp_q - SPW'(1);

    // A push into a full stack overwrites the top entry in place.
    for (int k = 0; k < DEPTH; k++) begin
      stack_d[k] = stack_q[k];
      if (push && !clr &&
          (sp_q == SPW'(k) || (k == DEPTH - 1 && sp_q == SPW'(DEPTH))))
        stack_d[k] = upc_q;
    end

    full_d = (sp_d == SPW'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc_q   <= '0;
      r_q     <= '0;
      sp_q    <= '0;
      full_q  <= 1'b0;
      stack_q <= '{default: '0};
    end else begin
      upc_q   <= upc_d;
      r_q     <= r_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      stack_q <= stack_d;
    end
  end

  assign full = full_q;

endmodule

// File: tb/tb_am2910_sequencer.sv
// Randomized and directed stimulus for am2910_sequencer, checked against a
// queue-based behavioural model of the sequencer.
module tb_am2910_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i = 4'd14;
  logic [11:0] d = '0;
  logic        cond = 1'b0, ccen = 1'b1, rld = 1'b0, ci = 1'b0;
  logic [11:0] y;
  logic        full, pl_en, map_en, vect_en;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [11:0] m_upc;
  logic [11:0] m_r;
  logic [11:0] stk[$];

  am2910_sequencer #(.WIDTH(12), .DEPTH(5)) dut (
    .clock(clock), .reset(reset), .i(i), .d(d), .cond(cond), .ccen(ccen),
    .rld(rld), .ci(ci), .y(y), .full(full), .pl_en(pl_en),
    .map_en(map_en), .vect_en(vect_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One instruction cycle: drive, check combinational outputs mid-cycle,
  // clock it, advance the model, then check the registered full flag.
  task automatic step(input logic [3:0] ii, input logic [11:0] dd,
                      input logic cc, input logic ce, input logic rl, input logic c);
    logic        ps, rzero;
    logic [11:0] ey, top;
    logic        psh, pp, clr, ld, dec;
    i = ii; d = dd; cond = cc; ccen = ce; rld = rl; ci = c;
    @(negedge clock);
    ps    = !ce || cc;
    rzero = (m_r == 0);
    top   = (stk.size() > 0) ? stk[$] : 12'h000;
    ey = m_upc; psh = 0; pp = 0; clr = 0; ld = 0; dec = 0;
    case (ii)
      4'd0:  begin ey = 0; clr = 1; end
      4'd1:  if (ps) begin ey = dd; psh = 1; end
      4'd2:  ey = dd;
      4'd3:  if (ps) ey = dd;
      4'd4:  begin psh = 1; ld = ps; end
      4'd5:  begin ey = ps ? dd : m_r; psh = 1; end
      4'd6:  if (ps) ey = dd;
      4'd7:  ey = ps ? dd : m_r;
      4'd8:  if (rzero) pp = 1; else begin ey = top; dec = 1; end
      4'd9:  if (!rzero) begin ey = dd; dec = 1; end
      4'd10: if (ps) begin ey = top; pp = 1; end
      4'd11: if (ps) begin ey = dd; pp = 1; end
      4'd12: ld = 1;
      4'd13: if (ps) pp = 1; else ey = top;
      4'd14: ;
      default: begin
        if (!rzero && !ps) begin ey = top; dec = 1; end
        else if (rzero && !ps) begin ey = dd; pp = 1; end
        else pp = 1;
      end
    endcase
    chk($sformatf("y i=%0d", ii), y, ey);
    chk($sformatf("en i=%0d", ii), {pl_en, map_en, vect_en},
        {ii != 2 && ii != 6, ii == 2, ii == 6});
    @(posedge clock);
    if (clr) stk.delete();
    else if (psh) begin
      if (stk.size() == 5) stk[4] = m_upc;
      else stk.push_back(m_upc);
    end else if (pp && stk.size() > 0) void'(stk.pop_back());
    if (rl || ld) m_r = dd;
    else if (dec) m_r = m_r - 1;
    m_upc = ey + {11'd0, c};
    #1;
    chk("full", full, stk.size() == 5);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic areset();
    i = 4'd14; ci = 1'b0; rld = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async rst y", y, 12'h000);
    chk("async rst full", full, 1'b0);
    m_upc = 0; m_r = 0; stk.delete();
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    m_upc = 0; m_r = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst y", y, 12'h000);
    chk("rst full", full, 1'b0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;

    // CONT with ci=1: 0,1,2,3 then async reset
    repeat (4) step(4'd14, 12'h0, 0, 1, 0, 1);
    areset();

    // Subroutine call/return
    step(4'd3,  12'h010, 1, 1, 0, 0);
    step(4'd1,  12'h200, 1, 1, 0, 0);
    chk("cjs push", stk.size(), 1);
    step(4'd10, 12'h000, 1, 1, 0, 0);
    chk("crtn pop", stk.size(), 0);
    step(4'd1,  12'h200, 0, 1, 0, 0);

    // Counted loop, then rld override during RPCT
    step(4'd12, 12'd3, 0, 1, 0, 1);
    repeat (4) step(4'd9, 12'h050, 0, 1, 0, 1);
    step(4'd12, 12'd3, 0, 1, 0, 1);
    step(4'd9, 12'd7, 0, 1, 1, 1);
    chk("rld R", m_r, 12'd7);
    step(4'd7, 12'h000, 0, 1, 0, 0);  // JRP fail exposes R on y

    // Overflow / underflow
    step(4'd0, 12'h0, 0, 1, 0, 0);
    step(4'd3, 12'h100, 1, 1, 0, 0);
    repeat (6) step(4'd4, 12'h0, 0, 1, 0, 1);
    repeat (6) step(4'd10, 12'h0, 1, 1, 0, 0);

    // TWB all branches, with and without ccen
    for (int pass_forced = 0; pass_forced < 2; pass_forced++) begin
      step(4'd0, 12'h0, 0, 1, 0, 1);
      repeat (3) step(4'd4, 12'h0, 0, 1, 0, 1);
      step(4'd12, 12'd2, 0, 1, 0, 1);
      step(4'd15, 12'h3A0, 0, pass_forced == 0, 0, 1);
      step(4'd15, 12'h3A0, 1, 1, 0, 1);
      step(4'd12, 12'd0, 0, 1, 0, 1);
      step(4'd15, 12'h3B0, 0, pass_forced == 0, 0, 1);
      step(4'd15, 12'h3C0, 1, 1, 0, 1);
    end

    // Every opcode once for the enables; JZ with sp=3
    for (int k = 0; k < 16; k++) step(4'(k), 12'(12'h400 + k), 1, 1, 0, 1);
    repeat (3) step(4'd4, 12'h0, 0, 1, 0, 1);
    step(4'd0, 12'h0, 0, 1, 0, 1);
    chk("jz clr", stk.size(), 0);

    // uPC wrap
    step(4'd3, 12'hFFF, 1, 1, 0, 0);
    step(4'd14, 12'h0, 0, 1, 0, 1);
    step(4'd14, 12'h0, 0, 1, 0, 1);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) areset();
      else step(4'($urandom_range(0, 15)), 12'($urandom),
                1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am2910_sequencer.md
# am2910_sequencer

Microprogram next-address sequencer in the Am2910 style. It generates the microcode ROM address every cycle, and the resulting microword drives the Am2901 slice control fields. It holds a microprogram counter (uPC), a register/counter (R), and a 5-deep subroutine/loop stack. It implements the 16 standard Am2910 instructions, with a condition input normally fed from the slice flags (fzero, cout, f3, ovr).

## Interface
- WIDTH, 12: address, counter and stack-entry width.
- DEPTH, 5: stack entries.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- i  in  4  instruction code, 0..15.
- d  in  WIDTH  direct input (branch address or count).
- cond  in  1  test condition, active-high.
- ccen  in  1  condition enable. When 0, pass is forced to 1.
- rld  in  1  forces R <= d this clock, active-high.
- ci  in  1  incrementer carry. uPC <= y + ci.
- y  out  WIDTH  next microaddress, combinational.
- full  out  1  sp == DEPTH.
- pl_en, map_en, vect_en  out  1 each  D-source enables. Exactly one is high.

## Operation
- pass = !ccen | cond. rz = (R == 0). F = stack[sp-1] when sp > 0, else 0.
- Instructions, given as pass / fail results. "push" means stack[sp] <= uPC, sp++. "pop" means sp--.
  - 0 JZ: y=0; sp <= 0.
  - 1 CJS: pass: y=d, push. fail: y=uPC.
  - 2 JMAP: y=d; map_en=1.
  - 3 CJP: pass: y=d. fail: y=uPC.
  - 4 PUSH: y=uPC; push; additionally R <= d when pass.
  - 5 JSRP: y = pass ? d : R; push.
  - 6 CJV: pass: y=d. fail: y=uPC. vect_en=1.
  - 7 JRP: y = pass ? d : R.
  - 8 RFCT: !rz: y=F, R <= R-1. rz: y=uPC, pop.
  - 9 RPCT: !rz: y=d, R <= R-1. rz: y=uPC.
  - 10 CRTN: pass: y=F, pop. fail: y=uPC.
  - 11 CJPP: pass: y=d, pop. fail: y=uPC.
  - 12 LDCT: y=uPC; R <= d.
  - 13 LOOP: pass: y=uPC, pop. fail: y=F.
  - 14 CONT: y=uPC.
  - 15 TWB:
    - !rz & fail: y=F, R <= R-1.
    - !rz & pass: y=uPC, pop.
    - rz & fail: y=d, pop.
    - rz & pass: y=uPC, pop.
- The D-source enable is decided by i alone. map_en=1 only for i=2, vect_en=1 only for i=6, pl_en=1 otherwise.
- Every cycle: uPC <= y + ci, modulo 2^WIDTH (0xFFF+1 wraps to 0x000).
- R arithmetic is unsigned, WIDTH bits. A decrement only occurs when R != 0, so R never underflows.
- rld=1 overrides any instruction load or decrement: R <= d.
- Push when full: overwrite stack[DEPTH-1]; sp stays DEPTH.
- Pop when empty: no-op; sp stays 0.
- The push for the current instruction captures the current uPC, not the new one.

## Timing
- y, pl_en, map_en and vect_en are purely combinational from i, cond, ccen, d, uPC, R and the stack top. There are no clocked outputs except full.
- uPC, R, sp and the stack array update on the rising clock edge. The address presented in cycle n is fetched, and its microword executes in cycle n+1 (pipeline register external).
- Reset is asynchronous and takes effect immediately: uPC=0, R=0, sp=0, full=0. The stack contents need not be cleared, but F reads 0 while sp=0.
- After reset with i=14, y=0x000. Asserting reset mid-loop or mid-subroutine discards all stack state.
- full is registered from sp. It rises in the same edge that makes sp == DEPTH.

## Test plan
- Reset then CONT with ci=1 for 3 clocks → y = 0x000, 0x001, 0x002, 0x003. Then reset asynchronously mid-cycle → y = 0x000 immediately.
- Subroutine call and return:
  - With uPC=0x010, apply CJS, d=0x200, cond=1 → y=0x200; after the clock sp=1 and the stack top is 0x010.
  - Then CRTN, cond=1 → y=0x010; after the clock sp=0.
  - CJS with cond=0 → y=0x010 and no push.
- Counted loop:
  - LDCT with d=3, then RPCT with d=0x050 → y=0x050 for 3 cycles, with R going 3→2→1→0.
  - The 4th cycle gives y=uPC.
  - rld=1 with d=7 during RPCT → R=7 and no decrement.
- Stack overflow and underflow:
  - 6 PUSHes from uPC=0x100..0x105 → full=1 after the 5th, and the 6th overwrites the top with 0x105.
  - 6 CRTNs with cond=1 → y = 0x105, 0x103, 0x102, 0x101, 0x100, then 0; sp ends at 0 with no wrap.
- TWB, all 4 branches:
  - R=2, cond=0 → y=F, R=1.
  - R=2, cond=1 → y=uPC, pop.
  - R=0, cond=0 → y=d, pop.
  - R=0, cond=1 → y=uPC, pop.
  - ccen=0 forces pass in every case.
- Enables and other results:
  - JMAP → map_en=1 and y=d. CJV → vect_en=1. Every other code → pl_en=1.
  - JZ with sp=3 → y=0 and sp=0.
  - uPC=0xFFF, CONT, ci=1 → next y=0x000.
